// File: rtl/openram_scan_pkg.sv
// Shared definitions for the OpenRAM testchip scan driver: packet layout,
// header mask, FSM encoding and a packet-builder helper.
package openram_scan_pkg;

  localparam int TOTAL_SIZE   = 112;
  localparam int PACKET_WIDTH = TOTAL_SIZE;

  localparam int SEL_LSB    = 108;
  localparam int ADDR0_LSB  = 92;
  localparam int DIN0_LSB   = 60;
  localparam int CSB0       = 59;
  localparam int WEB0       = 58;
  localparam int WMASK0_LSB = 54;
  localparam int ADDR1_LSB  = 38;
  localparam int DIN1_LSB   = 6;
  localparam int CSB1       = 5;
  localparam int WEB1       = 4;
  localparam int WMASK1_LSB = 0;

  localparam logic [PACKET_WIDTH-1:0] DIN_FIELD =
    {{(PACKET_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};

  // Everything except the two data-in fields, which carry read data on return.
  localparam logic [PACKET_WIDTH-1:0] HEADER_MASK =
    ~((DIN_FIELD << DIN0_LSB) | (DIN_FIELD << DIN1_LSB));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_LOAD,
    ST_SRAM_CLK,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_RESP
  } state_t;

  function automatic logic [PACKET_WIDTH-1:0] pack_cmd(
    input logic [3:0]  sel,
    input logic [15:0] addr0,
    input logic [31:0] din0,
    input logic        csb0,
    input logic        web0,
    input logic [3:0]  wmask0,
    input logic [15:0] addr1,
    input logic [31:0] din1,
    input logic        csb1,
    input logic        web1,
    input logic [3:0]  wmask1
  );
    logic [PACKET_WIDTH-1:0] p;
    p = '0;
    p[SEL_LSB +: 4]     = sel;
    p[ADDR0_LSB +: 16]  = addr0;
    p[DIN0_LSB +: 32]   = din0;
    p[CSB0]             = csb0;
    p[WEB0]             = web0;
    p[WMASK0_LSB +: 4]  = wmask0;
    p[ADDR1_LSB +: 16]  = addr1;
    p[DIN1_LSB +: 32]   = din1;
    p[CSB1]             = csb1;
    p[WEB1]             = web1;
    p[WMASK1_LSB +: 4]  = wmask1;
    return p;
  endfunction

endpackage

// File: rtl/openram_scan_phase_gen.sv
// Bit-slot phase generator: CLK_DIV cycles low, CLK_DIV cycles high, with
// strobes on the last cycle of each phase. Deasserting en restarts it low.
module openram_scan_phase_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic gpio_clk,
  output logic low_end,
  output logic high_end
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("openram_scan_phase_gen: CLK_DIV must be >= 1");
  end

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign wrap     = en && (cnt == LAST);
  assign low_end  = wrap && !phase;
  assign high_end = wrap && phase;
  assign gpio_clk = phase;

endmodule

// File: rtl/openram_scan_driver.sv
// Scan-chain initiator for the OpenRAM testchip: shift a command in, strobe
// load/SRAM clock/capture, shift the response out. Optional header compare
// under `define OPENRAM_SCAN_DRIVER_CHECK_EN.
module openram_scan_driver
  import openram_scan_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PACKET_WIDTH-1:0] cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PACKET_WIDTH-1:0] rsp_data,
  output logic                    rsp_mismatch,
  output logic                    busy,
  output logic                    gpio_clk_o,
  output logic                    gpio_in_o,
  output logic                    gpio_scan_o,
  output logic                    gpio_sram_load_o,
  output logic                    sram_clk_o,
  input  logic                    gpio_out_i
);

  localparam int W  = PACKET_WIDTH;
  localparam int CW = $clog2(PACKET_WIDTH + 1);

  state_t          state, state_next;
  logic [W-1:0]    tx_shreg, rx_shreg;
  logic [CW-1:0]   bit_cnt;
  logic            phase_en, phase_clk, low_end, high_end;
  logic            last_bit;

  assign phase_en = state inside {ST_SHIFT_IN, ST_LOAD, ST_SRAM_CLK,
                                  ST_CAPTURE, ST_UNLOAD};
  assign last_bit = high_end && (bit_cnt == CW'(1));

  openram_scan_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .en       (phase_en),
    .gpio_clk (phase_clk),
    .low_end  (low_end),
    .high_end (high_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE:     if (cmd_valid) bit_cnt <= CW'(PACKET_WIDTH);
        ST_CAPTURE:  if (high_end)  bit_cnt <= CW'(PACKET_WIDTH);
        ST_SHIFT_IN,
        ST_UNLOAD:   if (high_end)  bit_cnt <= bit_cnt - CW'(1);
        default:     ;
      endcase
    end
  end

  // NOTE: the shift registers are pure datapath and are not reset; every
  // output derived from them is gated by state, which is.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE:     if (cmd_valid) tx_shreg <= cmd_data;
      ST_SHIFT_IN: if (high_end)  tx_shreg <= tx_shreg << 1;
      ST_UNLOAD:   if (low_end)   rx_shreg <= {rx_shreg[W-2:0], gpio_out_i};
      default:     ;
    endcase
  end

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a signal unassigned (no latches).
  always_comb begin
    state_next       = state;
    cmd_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_data         = '0;
    busy             = 1'b1;
    gpio_clk_o       = 1'b0;
    gpio_in_o        = 1'b0;
    gpio_scan_o      = 1'b0;
    gpio_sram_load_o = 1'b0;
    sram_clk_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = ST_SHIFT_IN;
      end
      ST_SHIFT_IN: begin
        gpio_scan_o = 1'b1;
        gpio_in_o   = tx_shreg[W-1];
        gpio_clk_o  = phase_clk;
        if (last_bit) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        gpio_sram_load_o = 1'b1;
        gpio_clk_o       = phase_clk;
        if (high_end) state_next = ST_SRAM_CLK;
      end
      ST_SRAM_CLK: begin
        sram_clk_o = !phase_clk;
        if (high_end) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        gpio_sram_load_o = 1'b1;
        gpio_clk_o       = phase_clk;
        if (high_end) state_next = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        gpio_scan_o = 1'b1;
        gpio_clk_o  = phase_clk;
        if (last_bit) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rx_shreg;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef OPENRAM_SCAN_DRIVER_CHECK_EN
  logic [W-1:0] hdr_copy;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cmd_valid) hdr_copy <= cmd_data & HEADER_MASK;
  end

  assign rsp_mismatch = (state == ST_RESP) &&
                        (|((rx_shreg & HEADER_MASK) ^ hdr_copy));
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_openram_scan_driver.sv
// Directed bench: two drivers (CLK_DIV=1 and 3), each attached to a
// behavioural testchip model (scan chain + two-port SRAM).
module tb_openram_scan_driver;
  import openram_scan_pkg::*;

  localparam int W     = PACKET_WIDTH;
  localparam int LIMIT = 5000;

  logic             clk = 1'b0;
  logic [1:0]       reset, cmd_valid, rsp_ready, corrupt;
  logic [W-1:0]     cmd_data [2];
  wire  [1:0]       cmd_ready, rsp_valid, rsp_mismatch, busy;
  wire  [1:0]       gpio_clk, gpio_in, gpio_scan, gpio_load, sram_clk, gpio_out;
  wire  [W-1:0]     rsp_data [2];

  int tests = 0;
  int fails = 0;
  int clk_period, clk_high;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    openram_scan_driver #(.CLK_DIV(g == 0 ? 1 : 3)) u_dut (
      .clk              (clk),
      .reset            (reset[g]),
      .cmd_valid        (cmd_valid[g]),
      .cmd_ready        (cmd_ready[g]),
      .cmd_data         (cmd_data[g]),
      .rsp_valid        (rsp_valid[g]),
      .rsp_ready        (rsp_ready[g]),
      .rsp_data         (rsp_data[g]),
      .rsp_mismatch     (rsp_mismatch[g]),
      .busy             (busy[g]),
      .gpio_clk_o       (gpio_clk[g]),
      .gpio_in_o        (gpio_in[g]),
      .gpio_scan_o      (gpio_scan[g]),
      .gpio_sram_load_o (gpio_load[g]),
      .sram_clk_o       (sram_clk[g]),
      .gpio_out_i       (gpio_out[g])
    );

    // Testchip model: chain shifts on gpio_clk while scanning; the first
    // load pulse copies the chain to the SRAM ports, the one after an SRAM
    // clock copies read data back into the chain.
    logic [W-1:0]  chain, cmd_reg, cap;
    logic [31:0]   mem [16];
    logic [31:0]   dout0, dout1;
    logic          ran = 1'b0;

    assign gpio_out[g] = chain[W-1];

    always_comb begin
      cap = cmd_reg;
      if (!cmd_reg[CSB0] && cmd_reg[WEB0]) cap[DIN0_LSB +: 32] = dout0;
      if (!cmd_reg[CSB1] && cmd_reg[WEB1]) cap[DIN1_LSB +: 32] = dout1;
      if (corrupt[g]) cap[40] = ~cap[40];
    end

    always @(posedge gpio_clk[g] or posedge sram_clk[g]) begin
      if (sram_clk[g]) begin
        ran <= 1'b1;
        if (!cmd_reg[CSB0]) begin
          if (!cmd_reg[WEB0])
            mem[cmd_reg[ADDR0_LSB +: 4]] <= merge(mem[cmd_reg[ADDR0_LSB +: 4]],
              cmd_reg[DIN0_LSB +: 32], cmd_reg[WMASK0_LSB +: 4]);
          else
            dout0 <= mem[cmd_reg[ADDR0_LSB +: 4]];
        end
        if (!cmd_reg[CSB1]) begin
          if (!cmd_reg[WEB1])
            mem[cmd_reg[ADDR1_LSB +: 4]] <= merge(mem[cmd_reg[ADDR1_LSB +: 4]],
              cmd_reg[DIN1_LSB +: 32], cmd_reg[WMASK1_LSB +: 4]);
          else
            dout1 <= mem[cmd_reg[ADDR1_LSB +: 4]];
        end
      end else if (gpio_scan[g]) begin
        chain <= {chain[W-2:0], gpio_in[g]};
      end else if (gpio_load[g]) begin
        if (!ran) cmd_reg <= chain;
        else begin
          chain <= cap;
          ran   <= 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] out_vec(input int i);
    return {cmd_ready[i], rsp_valid[i], rsp_mismatch[i], busy[i], gpio_clk[i],
            gpio_in[i], gpio_scan[i], gpio_load[i], sram_clk[i]};
  endfunction

  task automatic send_cmd(input int i, input logic [W-1:0] cmd);
    int n = 0;
    @(negedge clk);
    cmd_valid[i] = 1'b1;
    cmd_data[i]  = cmd;
    while (!cmd_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready[i]) check("accept_timeout", 112'(cmd_ready[i]), 112'(1));
    @(posedge clk);
    #1 cmd_valid[i] = 1'b0;
  endtask

  // Counts edges from the accepting edge until rsp_valid is seen, tracking
  // the gpio_clk period and high time along the way.
  task automatic wait_rsp(input int i, output int lat);
    int  last_rise = -1;
    logic prev = 1'b0;
    lat = 0;
    while (lat < LIMIT) begin
      @(posedge clk);
      #1 lat++;
      if (gpio_clk[i] && !prev) begin
        if (last_rise >= 0) clk_period = lat - last_rise;
        last_rise = lat;
      end
      if (!gpio_clk[i] && prev) clk_high = lat - last_rise;
      prev = gpio_clk[i];
      if (rsp_valid[i]) break;
    end
    if (!rsp_valid[i]) check("rsp_timeout", 112'(rsp_valid[i]), 112'(1));
  endtask

  task automatic take_rsp(input int i);
    @(negedge clk);
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[i] = 1'b0;
  endtask

  task automatic run_cmd(input int i, input logic [W-1:0] cmd,
                         output logic [W-1:0] rsp, output logic mism,
                         output int lat);
    send_cmd(i, cmd);
    wait_rsp(i, lat);
    rsp  = rsp_data[i];
    mism = rsp_mismatch[i];
    take_rsp(i);
  endtask

  initial begin
    logic [W-1:0] cmd, rsp, exp, snap;
    logic         mism, stable, seen;
    int           lat;

    reset     = 2'b11;
    cmd_valid = 2'b00;
    rsp_ready = 2'b00;
    corrupt   = 2'b00;
    cmd_data[0] = '0;
    cmd_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 112'(out_vec(0)), 112'(9'b1_0000_0000));
    check("reset_rsp_data", rsp_data[0], '0);
    @(negedge clk) reset = 2'b00;

    // Port-0 write, port 1 idle.
    cmd = pack_cmd(4'd1, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF,
                   16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    run_cmd(0, cmd, rsp, mism, lat);
    check("write_latency", 112'(lat), 112'(454));
    check("write_header", rsp & HEADER_MASK, cmd & HEADER_MASK);
    check("write_mismatch", 112'(mism), 112'(0));

    cmd = pack_cmd(4'd1, 16'd2, 32'd2, 1'b0, 1'b0, 4'hF,
                   16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    run_cmd(0, cmd, rsp, mism, lat);
    check("write2_latency", 112'(lat), 112'(454));

    // Dual read: port 0 addr 1, port 1 addr 2.
    cmd = pack_cmd(4'd1, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0,
                   16'd2, 32'd0, 1'b0, 1'b1, 4'h0);
    exp = {4'd1, 16'd1, 32'd1, 1'b0, 1'b1, 4'd0,
           16'd2, 32'd2, 1'b0, 1'b1, 4'd0};
    run_cmd(0, cmd, rsp, mism, lat);
    check("read_data", rsp, exp);
    check("read_latency", 112'(lat), 112'(454));

    // Back-pressure: response held while a new command is offered.
    send_cmd(0, cmd);
    wait_rsp(0, lat);
    snap = rsp_data[0];
    check("hold_data", snap, exp);
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_data[0]  = pack_cmd(4'd2, 16'd2, 32'd0, 1'b0, 1'b1, 4'h0,
                            16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid[0] || rsp_data[0] !== snap || cmd_ready[0] || !busy[0])
        stable = 1'b0;
    end
    check("hold_stable", 112'(stable), 112'(1));
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    check("resp_done", 112'({cmd_ready[0], rsp_valid[0], busy[0]}), 112'(3'b100));
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    check("accept_after_resp", 112'(busy[0]), 112'(1));
    wait_rsp(0, lat);
    check("queued_read_data", 112'(rsp_data[0][DIN0_LSB +: 32]), 112'(32'd2));
    take_rsp(0);

    // Reset in the middle of shifting (slot 50).
    send_cmd(0, cmd);
    repeat (100) @(posedge clk);
    @(negedge clk) reset[0] = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_outputs", 112'(out_vec(0)), 112'(9'b1_0000_0000));
    check("midreset_rsp_data", rsp_data[0], '0);
    @(negedge clk) reset[0] = 1'b0;
    seen = 1'b0;
    repeat (500) begin
      @(posedge clk);
      #1 if (rsp_valid[0] || busy[0]) seen = 1'b1;
    end
    check("midreset_no_rsp", 112'(seen), 112'(0));
    cmd = pack_cmd(4'd3, 16'd2, 32'd0, 1'b0, 1'b1, 4'h0,
                   16'd7, 32'd0, 1'b1, 1'b1, 4'h0);
    run_cmd(0, cmd, rsp, mism, lat);
    check("post_reset_data", 112'(rsp[DIN0_LSB +: 32]), 112'(32'd2));
    check("post_reset_header", rsp & HEADER_MASK, cmd & HEADER_MASK);
    check("post_reset_latency", 112'(lat), 112'(454));

    // CLK_DIV = 3 instance.
    cmd = pack_cmd(4'd4, 16'd5, 32'hA5A5_5A5A, 1'b0, 1'b0, 4'hF,
                   16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    run_cmd(1, cmd, rsp, mism, lat);
    check("div3_latency", 112'(lat), 112'(1362));
    check("div3_period", 112'(clk_period), 112'(6));
    check("div3_high", 112'(clk_high), 112'(3));
    cmd = pack_cmd(4'd4, 16'd5, 32'd0, 1'b0, 1'b1, 4'h0,
                   16'd5, 32'd0, 1'b0, 1'b1, 4'h0);
    run_cmd(1, cmd, rsp, mism, lat);
    check("div3_read0", 112'(rsp[DIN0_LSB +: 32]), 112'(32'hA5A5_5A5A));
    check("div3_read1", 112'(rsp[DIN1_LSB +: 32]), 112'(32'hA5A5_5A5A));
    check("div3_header", rsp & HEADER_MASK, cmd & HEADER_MASK);

`ifdef OPENRAM_SCAN_DRIVER_CHECK_EN
    cmd = pack_cmd(4'd1, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0,
                   16'd2, 32'd0, 1'b0, 1'b1, 4'h0);
    corrupt[0] = 1'b1;
    run_cmd(0, cmd, rsp, mism, lat);
    corrupt[0] = 1'b0;
    check("corrupt_mismatch", 112'(mism), 112'(1));
    check("corrupt_bit40", 112'(rsp[40]), 112'(~cmd[40]));
    run_cmd(0, cmd, rsp, mism, lat);
    check("clean_mismatch", 112'(mism), 112'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
